// File: rtl/chess_pkg.sv
// Shared types and constants for the pawn move controller slice.
package chess_pkg;

  typedef logic [5:0] square_t;

  typedef enum logic [2:0] {
    ROAM,
    PICKED,
    CHECK,
    COMMIT,
    REJECT
  } state_t;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  localparam int unsigned ALLOW_FWD   = 0;
  localparam int unsigned ALLOW_CAP_L = 1;
  localparam int unsigned ALLOW_CAP_R = 2;

endpackage

// File: rtl/pawn_move_ctrl_if.sv
// Board-side signal bundle of the pawn move controller.
interface pawn_move_ctrl_if;
  import chess_pkg::*;

  logic    btnUp;
  logic    btnDown;
  logic    btnLeft;
  logic    btnRight;
  logic    btnSel;
  logic    btnCancel;
  logic    ownPawnAtCursor;
  logic [2:0] allow;
  square_t cursorPos;
  square_t queryPos;
  logic    queryColor;
  logic    moveValid;
  logic    moveReject;
  square_t moveFrom;
  square_t moveTo;
  logic    turn;

  modport master (
    input  btnUp, btnDown, btnLeft, btnRight, btnSel, btnCancel,
    input  ownPawnAtCursor, allow,
    output cursorPos, queryPos, queryColor, moveValid, moveReject,
    output moveFrom, moveTo, turn
  );

  modport slave (
    output btnUp, btnDown, btnLeft, btnRight, btnSel, btnCancel,
    output ownPawnAtCursor, allow,
    input  cursorPos, queryPos, queryColor, moveValid, moveReject,
    input  moveFrom, moveTo, turn
  );

endinterface

// File: rtl/cursor_stepper.sv
// One saturating cursor step per cycle; priority Up > Down > Left > Right.
module cursor_stepper
  import chess_pkg::*;
(
  input  square_t pos,
  input  logic    up,
  input  logic    down,
  input  logic    left,
  input  logic    right,
  output square_t pos_next
);

  always_comb begin
    pos_next = pos;
    if (up) begin
      if (pos[5:3] != 3'd7) pos_next[5:3] = pos[5:3] + 3'd1;
    end else if (down) begin
      if (pos[5:3] != 3'd0) pos_next[5:3] = pos[5:3] - 3'd1;
    end else if (left) begin
      if (pos[2:0] != 3'd0) pos_next[2:0] = pos[2:0] - 3'd1;
    end else if (right) begin
      if (pos[2:0] != 3'd7) pos_next[2:0] = pos[2:0] + 3'd1;
    end
  end

endmodule

// File: rtl/pawn_move_ctrl.sv
// Pawn move controller: cursor roaming, pick/target selection, pawn legality check.
module pawn_move_ctrl
  import chess_pkg::*;
#(
  parameter square_t CURSOR_INIT = 6'd12
) (
  input logic              clk,
  input logic              reset,
  pawn_move_ctrl_if.master bus
);

  state_t  state, state_nxt;
  square_t cursor, cursor_step, sel_pos, tgt_pos, query_pos, move_from, move_to;
  logic    turn_q;
  logic    buttons_live;
  logic    legal;
  logic signed [3:0] dr, rank_exp, df;

  assign buttons_live = (state == ROAM) || (state == PICKED);

  cursor_stepper u_step (
    .pos      (cursor),
    .up       (bus.btnUp    & buttons_live),
    .down     (bus.btnDown  & buttons_live),
    .left     (bus.btnLeft  & buttons_live),
    .right    (bus.btnRight & buttons_live),
    .pos_next (cursor_step)
  );

  // Off-board ranks (-1 or 8) can never match a 3-bit target rank, so they fall out as illegal.
  always_comb begin
    dr       = (turn_q == WHITE) ? 4'sd1 : -4'sd1;
    rank_exp = $signed({1'b0, sel_pos[5:3]}) + dr;
    df       = $signed({1'b0, tgt_pos[2:0]}) - $signed({1'b0, sel_pos[2:0]});
    legal    = (rank_exp == $signed({1'b0, tgt_pos[5:3]})) &&
               (((df == 4'sd0)  && bus.allow[ALLOW_FWD])   ||
                ((df == -4'sd1) && bus.allow[ALLOW_CAP_L]) ||
                ((df == 4'sd1)  && bus.allow[ALLOW_CAP_R]));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ROAM:    if (bus.btnSel && bus.ownPawnAtCursor) state_nxt = PICKED;
      PICKED:  if (bus.btnCancel) state_nxt = ROAM;
               else if (bus.btnSel) state_nxt = CHECK;
      CHECK:   state_nxt = legal ? COMMIT : REJECT;
      COMMIT:  state_nxt = ROAM;
      REJECT:  state_nxt = PICKED;
      default: state_nxt = ROAM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ROAM;
      cursor    <= CURSOR_INIT;
      sel_pos   <= '0;
      tgt_pos   <= '0;
      query_pos <= '0;
      move_from <= '0;
      move_to   <= '0;
      turn_q    <= WHITE;
    end else begin
      state <= state_nxt;
      if (buttons_live) cursor <= cursor_step;
      if (state == ROAM && state_nxt == PICKED) begin
        sel_pos   <= cursor;
        query_pos <= cursor;
      end
      if (state == PICKED && state_nxt == CHECK) tgt_pos <= cursor;
      if (state == CHECK && state_nxt == COMMIT) begin
        move_from <= sel_pos;
        move_to   <= tgt_pos;
      end
      if (state == COMMIT) turn_q <= ~turn_q;
    end
  end

  // Pulses are masked by reset so an abort suppresses them in the reset cycle itself.
  always_comb begin
    bus.cursorPos  = cursor;
    bus.queryPos   = query_pos;
    bus.queryColor = turn_q;
    bus.turn       = turn_q;
    bus.moveFrom   = move_from;
    bus.moveTo     = move_to;
    bus.moveValid  = (state == COMMIT) && !reset;
    bus.moveReject = (state == REJECT) && !reset;
  end

endmodule

// File: tb/tb_pawn_move_ctrl.sv
// Directed self-checking bench for pawn_move_ctrl.
module tb_pawn_move_ctrl;
  import chess_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pawn_move_ctrl_if bus ();

  pawn_move_ctrl #(.CURSOR_INIT(6'd12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.btnUp = 0; bus.btnDown = 0; bus.btnLeft = 0; bus.btnRight = 0;
    bus.btnSel = 0; bus.btnCancel = 0;
  endtask

  initial begin
    reset = 1;
    bus.btnUp = 0; bus.btnDown = 0; bus.btnLeft = 0; bus.btnRight = 0;
    bus.btnSel = 0; bus.btnCancel = 0; bus.ownPawnAtCursor = 0; bus.allow = 3'b000;
    tick(); tick();
    reset = 0;
    chk("rst_cursor", 8'(bus.cursorPos), 8'd12);
    chk("rst_query", 8'(bus.queryPos), 8'd0);
    chk("rst_turn", 8'(bus.turn), 8'd0);
    chk("rst_valid", 8'(bus.moveValid), 8'd0);
    chk("rst_from", 8'(bus.moveFrom), 8'd0);

    // White forward move o12 -> o22
    bus.btnLeft = 1; tick();
    bus.btnLeft = 1; tick();
    chk("cursor_o12", 8'(bus.cursorPos), 8'o12);
    bus.ownPawnAtCursor = 1; bus.btnSel = 1; tick();
    chk("pick_query", 8'(bus.queryPos), 8'o12);
    bus.btnUp = 1; tick();
    chk("cursor_o22", 8'(bus.cursorPos), 8'o22);
    bus.allow = 3'b001; bus.btnSel = 1; tick();
    chk("w_check_novalid", 8'(bus.moveValid), 8'd0);
    tick();
    chk("w_valid", 8'(bus.moveValid), 8'd1);
    chk("w_from", 8'(bus.moveFrom), 8'o12);
    chk("w_to", 8'(bus.moveTo), 8'o22);
    chk("w_turn_in_commit", 8'(bus.turn), 8'd0);
    tick();
    chk("w_turn", 8'(bus.turn), 8'd1);
    chk("w_qcolor", 8'(bus.queryColor), 8'd1);
    chk("w_valid_end", 8'(bus.moveValid), 8'd0);

    // Black: select o63, target o54 with wrong mask, then right mask
    for (int i = 0; i < 4; i++) begin bus.btnUp = 1; tick(); end
    bus.btnRight = 1; tick();
    chk("cursor_o63", 8'(bus.cursorPos), 8'o63);
    bus.btnSel = 1; tick();
    chk("b_query", 8'(bus.queryPos), 8'o63);
    bus.btnDown = 1; tick();
    bus.btnRight = 1; tick();
    chk("cursor_o54", 8'(bus.cursorPos), 8'o54);
    bus.allow = 3'b010; bus.btnSel = 1; tick();
    bus.btnUp = 1; tick();
    chk("b_reject", 8'(bus.moveReject), 8'd1);
    chk("b_reject_novalid", 8'(bus.moveValid), 8'd0);
    chk("btn_ignored_check", 8'(bus.cursorPos), 8'o54);
    tick();
    chk("b_back_picked", 8'(dut.state), 8'(PICKED));
    chk("b_reject_end", 8'(bus.moveReject), 8'd0);
    bus.allow = 3'b100; bus.btnSel = 1; tick();
    tick();
    chk("b_valid", 8'(bus.moveValid), 8'd1);
    chk("b_from", 8'(bus.moveFrom), 8'o63);
    chk("b_to", 8'(bus.moveTo), 8'o54);
    tick();
    chk("b_turn", 8'(bus.turn), 8'd0);

    // Priority and saturation
    bus.btnUp = 1; bus.btnDown = 1; tick();
    chk("prio_up", 8'(bus.cursorPos), 8'o64);
    bus.btnUp = 1; tick();
    for (int i = 0; i < 4; i++) begin bus.btnLeft = 1; tick(); end
    chk("cursor_o70", 8'(bus.cursorPos), 8'o70);
    bus.btnUp = 1; tick();
    chk("sat_up", 8'(bus.cursorPos), 8'o70);
    bus.btnLeft = 1; tick();
    chk("sat_left", 8'(bus.cursorPos), 8'o70);

    // Select without own pawn is ignored
    bus.ownPawnAtCursor = 0; bus.btnSel = 1; tick();
    chk("nopawn_state", 8'(dut.state), 8'(ROAM));
    chk("nopawn_query", 8'(bus.queryPos), 8'o63);

    // Cancel wins over select
    bus.ownPawnAtCursor = 1; bus.btnSel = 1; tick();
    chk("pick_o70", 8'(bus.queryPos), 8'o70);
    bus.btnSel = 1; bus.btnCancel = 1; tick();
    chk("cancel_state", 8'(dut.state), 8'(ROAM));
    tick();
    chk("cancel_novalid", 8'(bus.moveValid), 8'd0);
    chk("cancel_noreject", 8'(bus.moveReject), 8'd0);

    // Reset during CHECK
    for (int i = 0; i < 6; i++) begin bus.btnDown = 1; tick(); end
    chk("cursor_o10", 8'(bus.cursorPos), 8'o10);
    bus.btnSel = 1; tick();
    bus.btnUp = 1; tick();
    bus.allow = 3'b001; bus.btnSel = 1; tick();
    chk("pre_rst_check", 8'(dut.state), 8'(CHECK));
    reset = 1; #1;
    chk("rst_chk_novalid0", 8'(bus.moveValid), 8'd0);
    tick();
    reset = 0; #1;
    chk("rst_chk_novalid1", 8'(bus.moveValid), 8'd0);
    chk("rst_chk_state", 8'(dut.state), 8'(ROAM));
    chk("rst_chk_cursor", 8'(bus.cursorPos), 8'd12);
    chk("rst_chk_query", 8'(bus.queryPos), 8'd0);
    chk("rst_chk_from", 8'(bus.moveFrom), 8'd0);
    chk("rst_chk_to", 8'(bus.moveTo), 8'd0);
    chk("rst_chk_turn", 8'(bus.turn), 8'd0);

    // Reset during COMMIT suppresses the pulse and the turn toggle
    bus.btnSel = 1; tick();
    bus.btnUp = 1; tick();
    bus.btnSel = 1; tick();
    tick();
    chk("pre_rst_commit", 8'(dut.state), 8'(COMMIT));
    reset = 1; #1;
    chk("rst_commit_novalid", 8'(bus.moveValid), 8'd0);
    tick();
    reset = 0; #1;
    chk("rst_commit_turn", 8'(bus.turn), 8'd0);
    chk("rst_commit_from", 8'(bus.moveFrom), 8'd0);
    chk("rst_commit_novalid1", 8'(bus.moveValid), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pawn_move_ctrl.md
PAWN_MOVE_CTRL -- requirements
Module: pawn_move_ctrl

Interface
REQ-001 Parameter CURSOR_INIT, 6'd12, cursor position loaded at reset.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 btnUp, btnDown, btnLeft, btnRight  in  1 each  one-cycle, pre-debounced cursor-step pulses.
REQ-005 btnSel  in  1  one-cycle select/confirm pulse.
REQ-006 btnCancel  in  1  one-cycle abort pulse.
REQ-007 ownPawnAtCursor  in  1  board reports a pawn of the side to move at cursorPos.
REQ-008 allow  in  3  pawn rule mask for queryPos/queryColor: bit0 forward one, bit1 capture file-1, bit2 capture file+1.
REQ-009 cursorPos  out  6  current cursor; [5:3] rank, [2:0] file.
REQ-010 queryPos  out  6  registered square driven to the pawn rule block.
REQ-011 queryColor  out  1  colour of the side to move (0 white, 1 black).
REQ-012 moveValid  out  1  one-cycle pulse: move accepted.
REQ-013 moveReject  out  1  one-cycle pulse: target illegal.
REQ-014 moveFrom, moveTo  out  6 each  committed squares; stable from the moveValid cycle until the next commit.
REQ-015 turn  out  1  side to move; 0 white.

Function
REQ-016 FSM states: ROAM, PICKED, CHECK, COMMIT, REJECT.
REQ-017 ROAM: cursor steps on btn pulses; btnSel with ownPawnAtCursor=1 latches selPos=cursorPos, queryPos=cursorPos -> PICKED; btnSel with ownPawnAtCursor=0 is ignored.
REQ-018 PICKED: cursor still moves; btnSel latches tgtPos=cursorPos -> CHECK; btnCancel -> ROAM; btnSel and btnCancel in the same cycle: cancel wins.
REQ-019 Cursor stepping saturates at rank/file 0 and 7; no wrap-around.
REQ-020 Simultaneous direction pulses: priority Up > Down > Left > Right; one step per cycle.
REQ-021 CHECK (one cycle): dr = +1 for white, -1 for black; df = tgt file - sel file; legal iff tgt rank = sel rank + dr and ((df=0 and allow[0]) or (df=-1 and allow[1]) or (df=+1 and allow[2])).
REQ-022 Rank/file arithmetic uses 4-bit signed intermediates; out-of-board results are illegal.
REQ-023 CHECK legal -> COMMIT; illegal -> REJECT.
REQ-024 COMMIT (one cycle): moveValid=1, moveFrom=selPos, moveTo=tgtPos, turn toggles at the end of the cycle -> ROAM.
REQ-025 REJECT (one cycle): moveReject=1 -> PICKED, keeping selPos.
REQ-026 Buttons are ignored in CHECK, COMMIT and REJECT.
REQ-027 queryColor equals turn at all times; queryPos changes only on the ROAM->PICKED transition.
REQ-028 Latency: btnSel in PICKED -> moveValid or moveReject exactly 2 cycles later.

Reset
REQ-029 reset forces state ROAM; cursorPos=CURSOR_INIT; queryPos=0, selPos=0, tgtPos=0, moveFrom=0, moveTo=0; moveValid=0, moveReject=0; turn=0.
REQ-030 reset asserted in any state, including mid-CHECK or mid-COMMIT, aborts the operation: no move pulse in that cycle or the next.

Structure
REQ-031 Shared package chess_pkg holds the state enum, square type (6 bits), colour constants WHITE=0/BLACK=1, and the allow bit indices.
REQ-032 One sub-module cursor_stepper (position, 4 step pulses -> next position with saturation).

Verification
REQ-033 Reset, white, cursor on 6'o12 (rank1 file2), btnSel, btnUp, btnSel, allow=001 -> moveValid 2 cycles later, moveFrom=12, moveTo=22, turn=1.
REQ-034 Black, selected 6'o63, target 6'o54, allow=100 -> moveValid; same target with allow=010 -> moveReject, state back to PICKED.
REQ-035 Cursor at 6'o70, btnUp then btnLeft -> cursor stays 6'o70.
REQ-036 btnSel with ownPawnAtCursor=0 -> stays ROAM, queryPos unchanged.
REQ-037 btnSel and btnCancel in the same PICKED cycle -> ROAM, no pulse.
REQ-038 reset during CHECK -> no moveValid, all outputs at reset values the next cycle.
